// File: rtl/pdl_config_loader_if.sv
// Input-memory read port and configuration-bank write port of the PDL config loader.
// master = loader side, slave = memory / config bank side.
interface pdl_config_loader_if #(
  parameter int unsigned INMEM_ADDRESS_WIDTH = 17,
  parameter int unsigned IDX_WIDTH           = 6
);
  logic                           inputMemoryReadReq;
  logic                           inputMemoryReadAck;
  logic [INMEM_ADDRESS_WIDTH-1:0] inputMemoryReadAdd;
  logic                           inputMemoryReadDataValid;
  logic [7:0]                     inputMemoryReadData;
  logic                           cfgWrEn;
  logic [IDX_WIDTH-1:0]           cfgWrIdx;
  logic [124:0]                   cfgWrData;

  modport master (
    output inputMemoryReadReq, inputMemoryReadAdd, cfgWrEn, cfgWrIdx, cfgWrData,
    input  inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData
  );

  modport slave (
    input  inputMemoryReadReq, inputMemoryReadAdd, cfgWrEn, cfgWrIdx, cfgWrData,
    output inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData
  );
endinterface

// File: rtl/pdl_config_loader.sv
// Fetches the PDL configuration image byte by byte from SIRC input memory and writes one
// 125-bit entry per PUF output bit into the configuration bank.
module pdl_config_loader #(
  parameter int unsigned INMEM_ADDRESS_WIDTH = 17,
  parameter int unsigned BASE_ADDR           = 0,
  parameter int unsigned NUM_BITS            = 64,
  parameter int unsigned IDX_WIDTH           = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  pdl_config_loader_if.master        bus
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StReq      = 2'd1;
  localparam logic [1:0] StWaitData = 2'd2;
  localparam logic [1:0] StCommit   = 2'd3;

  localparam logic [INMEM_ADDRESS_WIDTH-1:0] BaseAddr = INMEM_ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [IDX_WIDTH-1:0]           LastIdx  = IDX_WIDTH'(NUM_BITS - 1);

  logic [1:0]                     state_q, state_d;
  logic [INMEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_WIDTH-1:0]           ent_q, ent_d;
  logic [3:0]                     byte_q, byte_d;
  // Only the 15 most recent bytes are kept; the 16th is merged straight into the write word.
  logic [119:0]                   asm_q, asm_d;
  logic                           req_q, req_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           wr_en_q, wr_en_d;
  logic [IDX_WIDTH-1:0]           wr_idx_q, wr_idx_d;
  logic [124:0]                   wr_data_q, wr_data_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ent_d     = ent_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = done_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          addr_d  = BaseAddr;
          ent_d   = '0;
          byte_d  = '0;
        end
      end
      StReq: begin
        if (bus.inputMemoryReadAck) begin
          req_d   = 1'b0;
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (bus.inputMemoryReadDataValid) begin
          asm_d = {bus.inputMemoryReadData, asm_q[119:8]};
          if (byte_q == 4'd15) begin
            state_d   = StCommit;
            wr_en_d   = 1'b1;
            wr_idx_d  = ent_q;
            wr_data_d = {bus.inputMemoryReadData[4:0], asm_q};
          end else begin
            byte_d  = byte_q + 4'd1;
            addr_d  = addr_q + INMEM_ADDRESS_WIDTH'(1);
            req_d   = 1'b1;
            state_d = StReq;
          end
        end
      end
      StCommit: begin
        if (ent_q == LastIdx) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          ent_d   = ent_q + IDX_WIDTH'(1);
          byte_d  = '0;
          addr_d  = addr_q + INMEM_ADDRESS_WIDTH'(1);
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= BaseAddr;
      ent_q     <= '0;
      byte_q    <= '0;
      asm_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ent_q     <= ent_d;
      byte_q    <= byte_d;
      asm_q     <= asm_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign bus.inputMemoryReadReq = req_q;
  assign bus.inputMemoryReadAdd = addr_q;
  assign bus.cfgWrEn            = wr_en_q;
  assign bus.cfgWrIdx           = wr_idx_q;
  assign bus.cfgWrData          = wr_data_q;

endmodule

// File: doc/pdl_config_loader.md
# pdl_config_loader

Upstream feeder for the dual-core PUF evaluation stage. On a start pulse it fetches the PDL configuration image from SIRC input memory one byte at a time and assembles each 16-byte group into a 128-bit word. It then writes the low 125 bits into the per-bit configuration bank, one entry per PUF output bit across both cores (entries 0–31 core0, 32–63 core1). It sits between the SIRC input-memory port and the configuration registers consumed by the PUF evaluation FSM.

## Interface
Parameters:
- INMEM_ADDRESS_WIDTH, 17, width of input-memory byte address
- BASE_ADDR, 0, input-memory address of first configuration byte
- NUM_BITS, 64, number of configuration entries to load
- IDX_WIDTH, 6, width of entry index; NUM_BITS ≤ 2^IDX_WIDTH

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the final commit completes
- done  out  1  set the cycle after the last entry commits; cleared by reset or by the next accepted start
- inputMemoryReadReq  out  1  read request, held until acknowledged
- inputMemoryReadAck  in  1  request accepted when req&ack in the same cycle
- inputMemoryReadAdd  out  INMEM_ADDRESS_WIDTH  byte address, valid while req is high
- inputMemoryReadDataValid  in  1  read data returned this cycle
- inputMemoryReadData  in  8  returned byte
- cfgWrEn  out  1  one-cycle write strobe into the config bank
- cfgWrIdx  out  IDX_WIDTH  entry being written
- cfgWrData  out  125  configuration word; bits [127:125] of the assembled word are discarded

## Operation
- States: IDLE, REQ, WAIT_DATA, COMMIT.
- IDLE: req=0, busy=0. When start=1, go to REQ. On entry: inputMemoryReadAdd=BASE_ADDR, entry index=0, byte index=0, done cleared, busy set.
- REQ: req=1. On req&ack, clear req the next cycle and go to WAIT_DATA. Ack while req=0 is ignored.
- WAIT_DATA: on DataValid, shift in the byte with assembly <= {data, assembly[127:8]}. The first byte of a group therefore lands in bits [7:0] and the 16th in [127:120].
  - If byte index = 15: go to COMMIT.
  - Otherwise: increment byte index, increment the address, and go to REQ.
- COMMIT: for one cycle drive cfgWrEn=1, cfgWrIdx=entry index, cfgWrData=assembly[124:0].
  - If entry index = NUM_BITS−1: set done, clear busy, go to IDLE.
  - Otherwise: increment entry index, reset byte index to 0, increment the address, and go to REQ.
- Byte address for entry i, byte j = BASE_ADDR + 16·i + j, computed modulo 2^INMEM_ADDRESS_WIDTH (silent wrap).
- At most one read is outstanding. DataValid outside WAIT_DATA is ignored.
- start while busy is ignored. start in the cycle done is set is ignored; done may only be re-armed from IDLE.
- Reset in any state, at any time:
  - next cycle: IDLE, with req=0, cfgWrEn=0, busy=0, done=0, address=BASE_ADDR, all counters 0;
  - no partial entry is committed.

## Timing
- Reset values: inputMemoryReadReq=0, inputMemoryReadAdd=BASE_ADDR, cfgWrEn=0, cfgWrIdx=0, cfgWrData=0, busy=0, done=0.
- start accepted at edge t: req=1 and busy=1 from t+1.
- With ack in the first req cycle and DataValid one cycle after ack, each byte takes 2 cycles.
- Each entry takes 16×2 + 1 (COMMIT) = 33 cycles. A NUM_BITS=64 load is 2112 cycles from the first req to the done rising edge.
- cfgWrEn rises the cycle after the 16th DataValid and lasts exactly one cycle. cfgWrIdx and cfgWrData are stable during that cycle.
- All outputs are registered.

## Test plan
- Reset, then idle 10 cycles: all outputs hold their reset values; no req.
- Memory model with 1-cycle ack and 1-cycle data returning byte = address[7:0]; NUM_BITS=64:
  - addresses 0..1023 are each requested exactly once, in order;
  - the entry 0 write has cfgWrData = 125 bits of 0x0F0E…0100 (truncated), cfgWrIdx=0;
  - 64 cfgWrEn pulses; done rises at cycle 2112 after the first req.
- Random ack delay (0–5 cycles) and random DataValid delay (1–8 cycles):
  - identical write contents to the previous test;
  - req never drops before ack;
  - never more than one read outstanding.
- Spurious DataValid in REQ and IDLE, spurious ack with req=0, and start pulses while busy: no state corruption and final contents unchanged.
- Reset asserted mid-entry 5 at byte 7: next cycle IDLE with busy=0, no cfgWrEn for entry 5; a new start restarts from BASE_ADDR with entry 0.
- BASE_ADDR = 2^17 − 8, NUM_BITS=1: the address wraps from 0x1FFFF to 0x00000 after byte 7; one commit; done=1.
